// File: rtl/rv_pipe_pkg.sv
// Shared encodings for the 5-stage RISC-V pipeline control: forward selects,
// result/PC select codes and the hazard sequencer state enumeration.
package rv_pipe_pkg;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [1:0] RESULT_LOAD = 2'b01;
   localparam logic [1:0] PC_SEQ      = 2'b00;

   typedef enum logic [1:0] {
      ST_RUN      = 2'b00,
      ST_MEM_WAIT = 2'b01,
      ST_ERR      = 2'b10
   } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Result visible one cycle after the qualifying cycle; never back-pressures.
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)
         cnt_d = '0;
      else if (inc_i && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: forwarding, load-use stall, redirect flush and a
// memory-wait freeze with watchdog; controls are combinational, state registered.
module hazard_ctrl
   import rv_pipe_pkg::*;
#(
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1D,
   input  logic [4:0]       Rs2D,
   input  logic [4:0]       Rs1E,
   input  logic [4:0]       Rs2E,
   input  logic [4:0]       RdE,
   input  logic [4:0]       RdM,
   input  logic [4:0]       RdW,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic [1:0]       ResultSrcE,
   input  logic [1:0]       PCSrcE,
   input  logic             MemReqM,
   input  logic             MemReadyM,
   input  logic             cnt_clr,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [7:0] TMO = 8'(TIMEOUT);

   hz_state_e  state_q;
   logic [7:0] wait_q;
   logic       mem_err_q;

   logic lw_stall, redirect, mem_hold, freeze;

   assign lw_stall = (ResultSrcE == RESULT_LOAD) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
   assign redirect = (PCSrcE != PC_SEQ);
   assign mem_hold = MemReqM && !MemReadyM;
   assign freeze   = mem_hold || (state_q == ST_ERR);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_RUN;
         wait_q    <= 8'd0;
         mem_err_q <= 1'b0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (mem_hold) begin
                  state_q <= ST_MEM_WAIT;
                  wait_q  <= 8'd1;
               end
            end
            ST_MEM_WAIT: begin
               if (!mem_hold) begin
                  state_q <= ST_RUN;
                  wait_q  <= 8'd0;
               end else if (wait_q == TMO) begin
                  state_q   <= ST_ERR;
                  mem_err_q <= 1'b1;
               end else begin
                  wait_q <= wait_q + 8'd1;
               end
            end
            ST_ERR: begin
               state_q <= ST_ERR;
            end
            default: begin
               state_q <= ST_RUN;
            end
         endcase
      end
   end

   // M has priority over W; x0 is hardwired and never forwarded.
   always_comb begin
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
      if (!rst) begin
         if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
            ForwardAE = FWD_MEM;
         else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
            ForwardAE = FWD_WB;
         if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
            ForwardBE = FWD_MEM;
         else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
            ForwardBE = FWD_WB;
      end
   end

   // While frozen, D/E flushes are held back so a pending redirect or
   // load-use bubble is re-evaluated on the release cycle instead of lost.
   always_comb begin
      StallF = 1'b0;
      StallD = 1'b0;
      StallE = 1'b0;
      StallM = 1'b0;
      FlushD = 1'b0;
      FlushE = 1'b0;
      FlushW = 1'b0;
      if (!rst) begin
         if (freeze) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else begin
            StallF = lw_stall;
            StallD = lw_stall;
            FlushE = lw_stall || redirect;
            FlushD = redirect;
         end
      end
   end

   assign mem_err = mem_err_q;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .inc_i (StallF),
      .cnt_o (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (cnt_clr),
      .inc_i (FlushD),
      .cnt_o (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios then randomized traffic, all
// outputs compared each cycle against a rule-level reference model.
module tb_hazard_ctrl;

   localparam int CNT_W   = 4;
   localparam int TIMEOUT = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
   logic             RegWriteM, RegWriteW;
   logic [1:0]       ResultSrcE, PCSrcE;
   logic             MemReqM, MemReadyM, cnt_clr;
   logic             StallF, StallD, StallE, StallM;
   logic             FlushD, FlushE, FlushW;
   logic [1:0]       ForwardAE, ForwardBE;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state: error flag, consecutive hold run, counter values
   bit m_err;
   int m_hold;
   int m_stall, m_flush;
   int e_fa, e_fb;
   bit e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fw;
   int hold_left;

   hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
      .RdM(RdM), .RdW(RdW), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
      .MemReqM(MemReqM), .MemReadyM(MemReadyM), .cnt_clr(cnt_clr),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int fwd_sel(input bit wm, input int rdm, input bit ww, input int rdw, input int rs);
      if (wm && rdm != 0 && rdm == rs) return 2;
      if (ww && rdw != 0 && rdw == rs) return 1;
      return 0;
   endfunction

   task automatic model_eval();
      bit lw, redir, frz;
      lw    = (ResultSrcE == 2'b01) && (RdE != 0) && (RdE == Rs1D || RdE == Rs2D);
      redir = (PCSrcE != 2'b00);
      frz   = (MemReqM && !MemReadyM) || m_err;
      e_fa  = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs1E);
      e_fb  = fwd_sel(RegWriteM, RdM, RegWriteW, RdW, Rs2E);
      e_sf = frz | lw;  e_sd = frz | lw;
      e_se = frz;       e_sm = frz;      e_fw = frz;
      e_fd = !frz && redir;
      e_fe = !frz && (lw || redir);
   endtask

   task automatic settle_check();
      #1;
      model_eval();
      check_eq("StallF", StallF, e_sf);
      check_eq("StallD", StallD, e_sd);
      check_eq("StallE", StallE, e_se);
      check_eq("StallM", StallM, e_sm);
      check_eq("FlushD", FlushD, e_fd);
      check_eq("FlushE", FlushE, e_fe);
      check_eq("FlushW", FlushW, e_fw);
      check_eq("ForwardAE", ForwardAE, e_fa);
      check_eq("ForwardBE", ForwardBE, e_fb);
      check_eq("mem_err", mem_err, m_err);
      check_eq("stall_cnt", stall_cnt, m_stall);
      check_eq("flush_cnt", flush_cnt, m_flush);
   endtask

   task automatic tick();
      @(posedge clk);
      model_eval();
      if (cnt_clr) begin
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (e_sf && m_stall < CNT_MAX) m_stall++;
         if (e_fd && m_flush < CNT_MAX) m_flush++;
      end
      if (!m_err) begin
         if (MemReqM && !MemReadyM) begin
            m_hold++;
            if (m_hold > TIMEOUT) m_err = 1;
         end else begin
            m_hold = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0; RdE = 0; RdM = 0; RdW = 0;
      RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0;
      MemReqM = 0; MemReadyM = 1; cnt_clr = 0;
   endtask

   // asserts rst mid-cycle, checks the immediate effect, releases at next negedge
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check_eq("rst_stall", {StallF, StallD, StallE, StallM}, 0);
      check_eq("rst_flush", {FlushD, FlushE, FlushW}, 0);
      check_eq("rst_fwd", {ForwardAE, ForwardBE}, 0);
      check_eq("rst_mem_err", mem_err, 0);
      check_eq("rst_cnt", {stall_cnt, flush_cnt}, 0);
      m_err = 0; m_hold = 0; m_stall = 0; m_flush = 0; hold_left = 0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      RegWriteM = 1; RdM = 3; Rs1E = 3; PCSrcE = 2'b01;
      @(negedge clk);
      do_reset();

      // forwarding priority
      idle();
      RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1;
      settle_check(); check_eq("fwd_mem", ForwardAE, 2); tick();
      RegWriteM = 0;
      settle_check(); check_eq("fwd_wb", ForwardAE, 1); tick();
      Rs1E = 0;
      settle_check(); check_eq("fwd_x0", ForwardAE, 0); tick();

      // load-use
      idle(); ResultSrcE = 2'b01; RdE = 7; Rs2D = 7;
      settle_check(); check_eq("lu_stallF", StallF, 1); check_eq("lu_flushE", FlushE, 1); tick();
      idle();
      settle_check(); check_eq("lu_cnt", stall_cnt, 1); tick();

      // redirect
      do_reset();
      idle(); PCSrcE = 2'b01;
      settle_check(); check_eq("rd_flushD", FlushD, 1); check_eq("rd_stallF", StallF, 0); tick();
      idle();
      settle_check(); check_eq("rd_cnt", flush_cnt, 1); tick();

      // three-cycle memory wait with a pending redirect
      do_reset();
      idle(); MemReqM = 1; MemReadyM = 0; PCSrcE = 2'b01;
      for (int i = 0; i < 3; i++) begin
         settle_check(); check_eq("mw_stallM", StallM, 1); check_eq("mw_flushD", FlushD, 0); tick();
      end
      MemReadyM = 1;
      settle_check(); check_eq("mw_rel_flushD", FlushD, 1); check_eq("mw_rel_stallM", StallM, 0); tick();
      idle();
      settle_check(); check_eq("mw_cnt", stall_cnt, 3); tick();

      // watchdog timeout then async reset out of ERR
      do_reset();
      idle(); MemReqM = 1; MemReadyM = 0;
      for (int i = 0; i < 6; i++) begin
         settle_check(); tick();
      end
      settle_check(); check_eq("to_err", mem_err, 1);
      MemReqM = 0; MemReadyM = 1;
      settle_check(); check_eq("to_frz", StallM, 1); tick();
      settle_check(); check_eq("to_sticky", mem_err, 1);
      RegWriteM = 1; RdM = 3; Rs1E = 3;
      do_reset();

      // counter saturation and clear-over-increment
      idle(); ResultSrcE = 2'b01; RdE = 9; Rs1D = 9;
      for (int i = 0; i < CNT_MAX + 3; i++) begin
         settle_check(); tick();
      end
      settle_check(); check_eq("sat_hold", stall_cnt, CNT_MAX);
      cnt_clr = 1;
      settle_check(); tick();
      cnt_clr = 0;
      settle_check(); check_eq("sat_clr", stall_cnt, 0); tick();

      // randomized traffic
      idle();
      hold_left = 0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 59) == 0) do_reset();
         Rs1D = 5'($urandom_range(0, 7)); Rs2D = 5'($urandom_range(0, 7));
         Rs1E = 5'($urandom_range(0, 7)); Rs2E = 5'($urandom_range(0, 7));
         RdE  = 5'($urandom_range(0, 7)); RdM  = 5'($urandom_range(0, 7));
         RdW  = 5'($urandom_range(0, 7));
         RegWriteM  = 1'($urandom_range(0, 1));
         RegWriteW  = 1'($urandom_range(0, 1));
         ResultSrcE = 2'($urandom_range(0, 3));
         PCSrcE     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         cnt_clr    = ($urandom_range(0, 31) == 0);
         if (hold_left == 0 && $urandom_range(0, 7) == 0) hold_left = $urandom_range(1, 7);
         if (hold_left > 0) begin
            MemReqM = 1; MemReadyM = 0; hold_left--;
         end else begin
            MemReqM = 1'($urandom_range(0, 1)); MemReadyM = 1;
         end
         settle_check();
         tick();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Hazard and stall sequencer for the 5-stage pipelined RISC-V datapath.
- Generates forwarding selects, load-use stall, and control-hazard flushes for the F/D/E/M/W register layers.
- Freezes the whole pipeline while a wait-stated data memory holds off a load or store, with a watchdog timeout.
- Keeps saturating stall-cycle and redirect counters for performance debug.

Parameters:
- CNT_W, 32, width of the performance counters.
- TIMEOUT, 16, maximum MEM_WAIT cycles before the error state; legal range 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- Rs1D, Rs2D  in  5  source register fields of the instruction in Decode (A1/A2).
- Rs1E, Rs2E, RdE  in  5  source/destination registers held in Execute.
- RdM, RdW  in  5  destination registers in Memory and Writeback.
- RegWriteM, RegWriteW  in  1  register-write enables in Memory and Writeback.
- ResultSrcE  in  2  result select in Execute; 2'b01 = load.
- PCSrcE  in  2  next-PC select; any value other than 2'b00 = redirect.
- MemReqM  in  1  Memory stage is performing a load or store.
- MemReadyM  in  1  data memory completes the access this cycle.
- cnt_clr  in  1  synchronous clear of both counters.
- StallF, StallD, StallE, StallM  out  1  hold the PC and the D/E/M layers.
- FlushD, FlushE, FlushW  out  1  bubble into the D/E/W layers.
- ForwardAE, ForwardBE  out  2  00 = RD1E/RD2E, 01 = ResultW, 10 = ALUResultM.
- mem_err  out  1  sticky watchdog error.
- stall_cnt, flush_cnt  out  CNT_W  performance counters.

Behaviour:
- Clock and reset: one clock, clk, rising edge. Reset is asynchronous and active-high on rst.
- Reset values: state RUN, wait counter 0, counters 0, mem_err 0. While rst is high, all stall, flush and forward outputs are 0.
- Forwarding (combinational, evaluated per operand, shown for A):
  - 10 if RegWriteM, RdM != 0 and RdM == Rs1E.
  - else 01 if RegWriteW, RdW != 0 and RdW == Rs1E.
  - else 00.
  - The M stage has priority over W. x0 is never forwarded.
- lwStall = (ResultSrcE == 01) and RdE != 0 and (RdE == Rs1D or RdE == Rs2D).
- redirect = (PCSrcE != 00).
- memHold = MemReqM and not MemReadyM.
- FSM states: RUN, MEM_WAIT, ERR.
  - RUN -> MEM_WAIT when memHold; the wait counter loads 1.
  - MEM_WAIT -> RUN on the first cycle memHold is low.
  - MEM_WAIT -> ERR when the wait counter reaches TIMEOUT while memHold is still high; otherwise the counter increments.
  - ERR is terminal until rst.
- Outputs in RUN (combinational):
  - StallF = StallD = lwStall.
  - FlushE = lwStall or redirect.
  - FlushD = redirect.
  - StallE = StallM = FlushW = 0.
- Freeze rule: memHold in any state, plus every cycle in ERR.
  - StallF, StallD, StallE and StallM are 1. FlushW = 1 so no duplicate writeback occurs.
  - FlushD and FlushE are 0: a redirect or lwStall pending in E/D is deferred, not lost, and re-evaluates once the freeze lifts.
  - The first wait cycle stalls combinationally in RUN; there is no one-cycle slip.
- Freeze release: when MemReadyM rises, that cycle's outputs follow RUN rules, and M/W advance on that edge.
- mem_err is set on entry to ERR and clears only on rst.
- Counters:
  - stall_cnt increments each cycle StallF = 1.
  - flush_cnt increments each cycle FlushD = 1.
  - Both saturate at all-ones.
  - cnt_clr zeros both counters and takes priority over increment in the same cycle.
- rst asserted mid-wait returns the FSM to RUN immediately; the in-flight access is abandoned.

Decomposition:
- Shared package rv_pipe_pkg holds:
  - Forward-select constants FWD_RF = 00, FWD_WB = 01, FWD_MEM = 10.
  - RESULT_LOAD = 2'b01 and PC_SEQ = 2'b00.
  - The state enumeration.
- One natural sub-module: sat_counter (CNT_W wide, inc/clr), instantiated twice.
- The forwarding comparator stays inline.

Test Plan:
- Forward priority: RdM = RdW = Rs1E = 5, RegWriteM = RegWriteW = 1 -> ForwardAE = 10. Drop RegWriteM -> 01. Set Rs1E = 0 -> 00.
- Load-use: ResultSrcE = 01, RdE = 7, Rs2D = 7 -> StallF = StallD = FlushE = 1 for one cycle; stall_cnt = 1.
- Redirect: PCSrcE = 01 -> FlushD = FlushE = 1, StallF = 0; flush_cnt increments to 1.
- Memory wait of 3 cycles: MemReqM = 1, MemReadyM low for 3 cycles -> all four stalls and FlushW held 3 cycles, state returns to RUN, stall_cnt = 3. A concurrent PCSrcE = 01 gives FlushD = 0 during the wait and 1 on the release cycle.
- Timeout with TIMEOUT = 4: MemReadyM held low for 6 cycles -> ERR entered after 4 wait cycles, mem_err = 1 sticky, freeze continues; asynchronous rst mid-ERR -> mem_err = 0 and all outputs 0 immediately.
- Counter edge: preload stall_cnt near saturation (CNT_W = 4), drive 3 stall cycles -> holds at 15; cnt_clr together with a stall -> 0.
